// File: rtl/bt_uart_pkg.sv
// Shared types and helpers for the Bluetooth UART receiver.
// Pure declarations, no latency.
// No flow control of its own.
package bt_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/bt_uart_fifo.sv
// Synchronous show-ahead byte FIFO with fill-level and next-fill-level outputs.
// Latency: a push shows at the head (when empty) one cycle later; pop is immediate.
// Backpressure: in_rdy drops when full unless the head is popped in the same cycle.
module bt_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_vld,
    input  logic [WIDTH-1:0]           in_dat,
    output logic                       in_rdy,
    output logic                       out_vld,
    output logic [WIDTH-1:0]           out_dat,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] count_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The head reads as zero while empty so the output is clean after reset.
    assign out_vld = (count != '0);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;
    assign do_pop  = out_vld && out_rdy;
    assign in_rdy  = (count != CW'(DEPTH)) || do_pop;
    assign do_push = in_vld && in_rdy;

    // Next fill level: simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointer and count state; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
        end
    end

    // Storage write; when full with a pop, this overwrites the slot being read out.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver with 16x oversampling feeding a show-ahead byte FIFO.
// Latency: 3 cycles pin-to-FSM; byte visible 1 cycle after the mid-stop sample.
// Backpressure: rx_ready pops the FIFO; rts_n rises at RTS_THRESHOLD, a byte arriving when full is dropped.
module bt_uart_rx
    import bt_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50000000,
    parameter int BAUD          = 115200,
    parameter int FIFO_DEPTH    = 8,
    parameter int RTS_THRESHOLD = 6
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            rx,
    output logic [7:0]                      rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic                            rts_n,
    output logic                            frame_err,
    output logic                            overrun_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD);
    localparam int DW  = $clog2(DIV + 1);
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [1:0]    line_live;
    logic          rx_fall;
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [DW-1:0] div_cnt;
    logic [OW-1:0] os_cnt;
    logic          tick;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          clr_cnt;
    logic          shift_en;
    logic          stop_smp;
    logic          push_vld;
    logic          fifo_in_rdy;
    logic [CW-1:0] count_nxt;

    // Two-flop synchroniser plus edge-detect history. line_live keeps rx_prev
    // at 0 until it is loaded from a genuine line sample rather than the
    // synchroniser's reset value, so a line held low through reset never looks
    // like a falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b0;
            line_live <= 2'b00;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync & line_live[1];
            line_live <= {line_live[0], 1'b1};
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;
    assign tick    = (state != IDLE) && (div_cnt == DW'(DIV - 1));

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle strobes: half-bit into the start bit, then full bits.
    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    state_nxt = START;
                    clr_cnt   = 1'b1;
                end
            end
            START: begin
                if (tick && os_cnt == OW'(OVERSAMPLE / 2 - 1)) begin
                    if (!rx_sync) begin
                        state_nxt = DATA;
                        clr_cnt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && os_cnt == OW'(OVERSAMPLE - 1)) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && os_cnt == OW'(OVERSAMPLE - 1)) begin
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tick divider and oversample counter; idle while waiting for a start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (clr_cnt || state == IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= os_cnt + OW'(1);
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // LSB-first data shift register and bit counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (clr_cnt) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt   <= bit_cnt + 3'd1;
            shift_reg <= {rx_sync, shift_reg[7:1]};
        end
    end

    assign push_vld = stop_smp && rx_sync;

    bt_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_vld    (push_vld),
        .in_dat    (shift_reg),
        .in_rdy    (fifo_in_rdy),
        .out_vld   (rx_valid),
        .out_dat   (rx_data),
        .out_rdy   (rx_ready),
        .count     (fifo_count),
        .count_nxt (count_nxt)
    );

    // Error pulses and RTS, all registered from the same cycle's decisions.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            rts_n       <= 1'b1;
        end else begin
            frame_err   <= stop_smp && !rx_sync;
            overrun_err <= push_vld && !fifo_in_rdy;
            rts_n       <= (count_nxt >= CW'(RTS_THRESHOLD));
        end
    end

endmodule

// File: tb/tb_bt_uart_rx.sv
// Directed bench for bt_uart_rx: table of single frames plus hand-built fill,
// overrun, simultaneous push/pop, glitch and mid-frame reset sequences.
module tb_bt_uart_rx;

    localparam int CLK_HZ  = 25000000;   // slower clock keeps the run short
    localparam int BAUD    = 115200;
    localparam int DIV     = (CLK_HZ + 8 * BAUD) / (16 * BAUD);   // 14
    localparam int BIT     = 16 * DIV;                            // cycles per bit
    // Start edge driven after posedge k: FSM enters START at k+3, start sample
    // 8*DIV later, stop sample nine bit periods after that.
    localparam int STOP_S  = 3 + 8 * DIV + 9 * 16 * DIV;
    localparam int RTS_TH  = 6;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rts_n;
    logic       frame_err;
    logic       overrun_err;
    logic [3:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int ferr_cyc = 0;
    int ovr_cyc = 0;
    int rts_bad = 0;
    int ferr0;
    int ovr0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic       exp_vld;
        logic [7:0] exp_dat;
        int         exp_ferr;
    } vec_t;

    vec_t tbl [4];

    bt_uart_rx #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .BAUD          (BAUD),
        .FIFO_DEPTH    (8),
        .RTS_THRESHOLD (RTS_TH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rts_n       (rts_n),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .fifo_count  (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse widths and RTS tracking, sampled on the falling edge.
    always @(negedge clock) begin
        if (mon_en) begin
            if (frame_err === 1'b1) ferr_cyc++;
            if (overrun_err === 1'b1) ovr_cyc++;
            if (rts_n !== (fifo_count >= 4'(RTS_TH))) rts_bad++;
        end
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        cycles(BIT);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            cycles(BIT);
        end
        rx = stop;
        cycles(BIT);
        rx = 1'b1;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
        tbl[1] = '{8'h3D, 1'b1, 1'b1, 8'h3D, 0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};

        reset    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        cycles(3);
        check("rst_valid", rx_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun_err, 0);
        check("rst_rts_n", rts_n, 1);
        check("rst_data", rx_data, 8'h00);
        reset = 1'b1;
        cycles(1);
        check("rts_n_after_release", rts_n, 0);
        mon_en = 1'b1;
        cycles(4);

        // Single byte with exact arrival cycle.
        ferr0 = ferr_cyc;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                cycles(STOP_S - 1);
                check("a5_valid_before_stop", rx_valid, 0);
                cycles(1);
                check("a5_valid", rx_valid, 1);
                check("a5_data", rx_data, 8'hA5);
                check("a5_count", fifo_count, 1);
            end
        join
        cycles(4);
        pop_one();
        check("a5_popped_valid", rx_valid, 0);
        check("a5_popped_count", fifo_count, 0);
        check("a5_no_ferr", ferr_cyc - ferr0, 0);

        // Table of single frames.
        for (int i = 0; i < 4; i++) begin
            ferr0 = ferr_cyc;
            ovr0  = ovr_cyc;
            send_frame(tbl[i].dat, tbl[i].stop);
            cycles(4);
            check($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].exp_vld);
            if (tbl[i].exp_vld) begin
                check($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp_dat);
            end
            check($sformatf("tbl%0d_ferr", i), ferr_cyc - ferr0, tbl[i].exp_ferr);
            check($sformatf("tbl%0d_ovr", i), ovr_cyc - ovr0, 0);
            pop_one();
            check($sformatf("tbl%0d_empty", i), rx_valid, 0);
        end

        // Fill to full back-to-back with no consumer.
        for (int i = 0; i < 8; i++) begin
            send_frame(8'(i), 1'b1);
            check($sformatf("fill%0d_count", i), fifo_count, i + 1);
            check($sformatf("fill%0d_rts_n", i), rts_n, (i + 1 >= RTS_TH) ? 1 : 0);
        end
        check("fill_head", rx_data, 8'h00);
        ovr0 = ovr_cyc;
        send_frame(8'h08, 1'b1);
        cycles(2);
        check("overrun_pulse", ovr_cyc - ovr0, 1);
        check("overrun_count", fifo_count, 8);
        check("overrun_head", rx_data, 8'h00);

        // Push into a full FIFO in the same cycle as a pop.
        ovr0 = ovr_cyc;
        fork
            send_frame(8'h09, 1'b1);
            begin
                cycles(STOP_S - 1);
                rx_ready = 1'b1;
                cycles(1);
                rx_ready = 1'b0;
            end
        join
        check("simpop_count", fifo_count, 8);
        check("simpop_no_ovr", ovr_cyc - ovr0, 0);
        check("simpop_head", rx_data, 8'h01);
        for (int j = 1; j < 8; j++) begin
            check($sformatf("drain%0d", j), rx_data, j);
            pop_one();
        end
        check("drain_last", rx_data, 8'h09);
        check("drain_count", fifo_count, 1);

        // Short low glitch on an idle line.
        ferr0 = ferr_cyc;
        ovr0  = ovr_cyc;
        rx = 1'b0;
        cycles(4 * DIV);
        rx = 1'b1;
        cycles(2 * BIT);
        check("glitch_count", fifo_count, 1);
        check("glitch_ferr", ferr_cyc - ferr0, 0);
        check("glitch_ovr", ovr_cyc - ovr0, 0);

        // Reset halfway through bit 3 of 0x55, released with the line low.
        rx = 1'b0;
        cycles(BIT);
        for (int b = 0; b < 3; b++) begin
            rx = b[0] ? 1'b0 : 1'b1;
            cycles(BIT);
        end
        rx = 1'b0;
        cycles(BIT / 2);
        mon_en = 1'b0;
        reset  = 1'b0;
        #2;
        check("arst_count", fifo_count, 0);
        check("arst_valid", rx_valid, 0);
        cycles(5);
        reset = 1'b1;
        cycles(2);
        mon_en = 1'b1;
        ferr0  = ferr_cyc;
        ovr0   = ovr_cyc;
        cycles(3 * BIT);
        check("low_after_reset_valid", rx_valid, 0);
        check("low_after_reset_count", fifo_count, 0);
        rx = 1'b1;
        cycles(BIT);
        send_frame(8'h55, 1'b1);
        cycles(4);
        check("post_reset_valid", rx_valid, 1);
        check("post_reset_data", rx_data, 8'h55);
        check("post_reset_count", fifo_count, 1);
        check("post_reset_ferr", ferr_cyc - ferr0, 0);
        check("post_reset_ovr", ovr_cyc - ovr0, 0);

        check("rts_tracks_count", rts_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
